// File: rtl/pipe_arb_pkg.sv
// Shared types and round-robin pick function for pipe_rr_arbiter.
// Lock-state encoding is only consumed when PIPE_ARB_LOCK_EN is defined.
package pipe_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    localparam int PICK_MAX = 16;

    // One-hot grant: first set bit of req scanning ptr, ptr+1, ... modulo n.
    function automatic logic [PICK_MAX-1:0] rr_pick(
        input logic [PICK_MAX-1:0] req,
        input logic [3:0]          ptr,
        input int                  n
    );
        logic [PICK_MAX-1:0] gnt;
        logic                found;
        int                  idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < PICK_MAX; i++) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[3:0]]) begin
                    gnt[idx[3:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/pipe_rr_pick.sv
// Combinational rotate / priority-encode / unrotate grant picker.
// Shared by both builds of pipe_rr_arbiter (PIPE_ARB_LOCK_EN or not).
module pipe_rr_pick
    import pipe_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt_oh,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_any
);

    always_comb begin
        o_gnt_oh = NREQ'(rr_pick(PICK_MAX'(i_req), 4'(i_ptr), NREQ));
        o_gnt_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (o_gnt_oh[k]) o_gnt_id = IDW'(k);
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// N-requester round-robin arbiter into one registered valid/ready stage.
// Define PIPE_ARB_LOCK_EN to hold the grant across multi-beat packets (i_last).
module pipe_rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter  int DWIDTH = 8,
    parameter  int NREQ   = 4,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ*DWIDTH-1:0] i_data,
    input  logic [NREQ-1:0]        i_valid,
    output logic [NREQ-1:0]        i_ready,
`ifdef PIPE_ARB_LOCK_EN
    input  logic [NREQ-1:0]        i_last,
`endif
    output logic [DWIDTH-1:0]      o_data,
    output logic                   o_valid,
    output logic [IDW-1:0]         o_id,
    input  logic                   o_ready
);

    logic [DWIDTH-1:0] r_data;
    logic              r_valid;
    logic [IDW-1:0]    r_id;
    logic [IDW-1:0]    r_ptr;

    logic              w_adv;
    logic [NREQ-1:0]   w_req;
    logic [NREQ-1:0]   w_gnt_oh;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_any;
    logic [DWIDTH-1:0] w_sel;
    logic [IDW-1:0]    w_ptr_nxt;

`ifdef PIPE_ARB_LOCK_EN
    lock_e             r_lock;
    logic [IDW-1:0]    r_lock_id;
    logic              w_last;

    // While locked only the owner may be picked; others wait even if it idles.
    assign w_req  = (r_lock == LOCKED)
                  ? (i_valid & (NREQ'(1) << r_lock_id))
                  : i_valid;
    assign w_last = |(i_last & w_gnt_oh);
`else
    assign w_req  = i_valid;
`endif

    assign w_adv = o_ready | ~r_valid;

    pipe_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_gnt_oh (w_gnt_oh),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_oh[k]) w_sel = i_data[k*DWIDTH +: DWIDTH];
        end
    end

    assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;

    assign i_ready = w_adv ? w_gnt_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_id      <= '0;
            r_ptr     <= '0;
`ifdef PIPE_ARB_LOCK_EN
            r_lock    <= UNLOCKED;
            r_lock_id <= '0;
`endif
        end else if (w_adv) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_sel;
                r_id    <= w_gnt_id;
`ifdef PIPE_ARB_LOCK_EN
                if (w_last) r_ptr <= w_ptr_nxt;
                unique case (r_lock)
                    UNLOCKED: begin
                        if (!w_last) begin
                            r_lock    <= LOCKED;
                            r_lock_id <= w_gnt_id;
                        end
                    end
                    LOCKED: begin
                        if (w_last) r_lock <= UNLOCKED;
                    end
                endcase
`else
                r_ptr   <= w_ptr_nxt;
`endif
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_id    = r_id;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed self-checking bench for pipe_rr_arbiter (NREQ=4, DWIDTH=8).
// Lock scenario runs only when PIPE_ARB_LOCK_EN is defined.
module tb_pipe_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_data;
    logic [3:0]  i_valid;
    logic [3:0]  i_ready;
`ifdef PIPE_ARB_LOCK_EN
    logic [3:0]  i_last;
`endif
    logic [7:0]  o_data;
    logic        o_valid;
    logic [1:0]  o_id;
    logic        o_ready;

    int checks   = 0;
    int failures = 0;

    pipe_rr_arbiter #(
        .DWIDTH (8),
        .NREQ   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
`ifdef PIPE_ARB_LOCK_EN
        .i_last  (i_last),
`endif
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_id    (o_id),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester protocol: a pending valid must hold with stable data.
    logic [3:0]  pend;
    logic [31:0] pdata;
    initial pend = '0;
    always @(negedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pend[k]) begin
                    assert (i_valid[k] && i_data[k*8 +: 8] == pdata[k*8 +: 8])
                    else $error("protocol violation on requester %0d", k);
                end
            end
            pend  <= i_valid & ~i_ready;
            pdata <= i_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
`ifdef PIPE_ARB_LOCK_EN
        i_last  = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        o_ready = 1'b1;
        i_data  = '0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || i_ready !== 4'b0000 || o_id !== 2'd0 || o_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle c=%0d got v=%b rdy=%b id=%0d d=%h exp v=0 rdy=0000 id=0 d=00",
                         c, o_valid, i_ready, o_id, o_data);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        do_reset();
        o_ready = 1'b1;
        i_data  = 32'hA3A2A1A0;
        i_valid = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << (i % 4);
            checks++;
            if (i_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rr_ready i=%0d got=%b exp=%b", i, i_ready, exp_rdy);
            end
            if (i > 0) begin
                exp_id = 2'((i - 1) % 4);
                checks++;
                if (o_valid !== 1'b1 || o_id !== exp_id || o_data !== (8'hA0 + 8'(exp_id))) begin
                    failures++;
                    $display("FAIL rr_out i=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                             i, o_valid, o_id, o_data, exp_id, 8'hA0 + 8'(exp_id));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        o_ready = 1'b0;
        i_data  = 32'h00550000;
        i_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_accept got=%b exp=0100", i_ready);
        end
        tick();
        i_data  = 32'h00000011;
        i_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (i_ready !== 4'b0000 || o_valid !== 1'b1 || o_data !== 8'h55 || o_id !== 2'd2) begin
                failures++;
                $display("FAIL bp_stall c=%0d got rdy=%b v=%b d=%h id=%0d exp rdy=0000 v=1 d=55 id=2",
                         c, i_ready, o_valid, o_data, o_id);
            end
            tick();
        end
        o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0001 || o_data !== 8'h55) begin
            failures++;
            $display("FAIL bp_release got rdy=%b d=%h exp rdy=0001 d=55", i_ready, o_data);
        end
        tick();
        i_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h11 || o_id !== 2'd0 || i_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_nobubble got v=%b d=%h id=%0d rdy=%b exp v=1 d=11 id=0 rdy=0000",
                     o_valid, o_data, o_id, i_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h11 || o_id !== 2'd0) begin
            failures++;
            $display("FAIL bp_drain got v=%b d=%h id=%0d exp v=0 d=11 id=0", o_valid, o_data, o_id);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        o_ready = 1'b1;
        i_data  = 32'h00220000;
        i_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0100) begin
            failures++;
            $display("FAIL ws_setup got=%b exp=0100", i_ready);
        end
        tick();
        i_data  = 32'h33003100;
        i_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b1000) begin
            failures++;
            $display("FAIL ws_grant3 got=%b exp=1000", i_ready);
        end
        tick();
        i_data[31:24] = 8'h34;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0010 || o_id !== 2'd3 || o_data !== 8'h33) begin
            failures++;
            $display("FAIL ws_grant1 got rdy=%b id=%0d d=%h exp rdy=0010 id=3 d=33", i_ready, o_id, o_data);
        end
        tick();
        i_data[15:8] = 8'h32;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b1000 || o_id !== 2'd1 || o_data !== 8'h31) begin
            failures++;
            $display("FAIL ws_regrant3 got rdy=%b id=%0d d=%h exp rdy=1000 id=1 d=31", i_ready, o_id, o_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_id !== 2'd3 || o_data !== 8'h34 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL ws_out3 got id=%0d d=%h v=%b exp id=3 d=34 v=1", o_id, o_data, o_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        o_ready = 1'b0;
        i_data  = 32'h00007700;
        i_valid = 4'b0010;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h77) begin
            failures++;
            $display("FAIL rm_loaded got v=%b d=%h exp v=1 d=77", o_valid, o_data);
        end
        rst     = 1'b1;
        i_valid = 4'b0000;
        tick();
        rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_id !== 2'd0) begin
            failures++;
            $display("FAIL rm_cleared got v=%b d=%h id=%0d exp v=0 d=00 id=0", o_valid, o_data, o_id);
        end
        i_data  = 32'h83008100;
        i_valid = 4'b1010;
        o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0010) begin
            failures++;
            $display("FAIL rm_ptr0 got=%b exp=0010", i_ready);
        end
        tick();
        checks++;
        if (o_id !== 2'd1 || o_data !== 8'h81 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_first got id=%0d d=%h v=%b exp id=1 d=81 v=1", o_id, o_data, o_valid);
        end
    endtask

`ifdef PIPE_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        o_ready = 1'b1;
        i_data  = 32'h0000000F;
        i_last  = 4'b0001;
        i_valid = 4'b0001;
        tick();
        i_data  = 32'h00002110;
        i_last  = 4'b0001;
        i_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0010 || o_id !== 2'd0 || o_data !== 8'h0F) begin
            failures++;
            $display("FAIL lk_start got rdy=%b id=%0d d=%h exp rdy=0010 id=0 d=0f", i_ready, o_id, o_data);
        end
        tick();
        i_data[15:8] = 8'h22;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0010 || o_id !== 2'd1 || o_data !== 8'h21) begin
            failures++;
            $display("FAIL lk_beat1 got rdy=%b id=%0d d=%h exp rdy=0010 id=1 d=21", i_ready, o_id, o_data);
        end
        tick();
        i_data[15:8] = 8'h23;
        i_last       = 4'b0011;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0010 || o_id !== 2'd1 || o_data !== 8'h22) begin
            failures++;
            $display("FAIL lk_beat2 got rdy=%b id=%0d d=%h exp rdy=0010 id=1 d=22", i_ready, o_id, o_data);
        end
        tick();
        i_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0001 || o_id !== 2'd1 || o_data !== 8'h23) begin
            failures++;
            $display("FAIL lk_beat3 got rdy=%b id=%0d d=%h exp rdy=0001 id=1 d=23", i_ready, o_id, o_data);
        end
        tick();
        i_data  = 32'h00003111;
        i_last  = 4'b0001;
        i_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0010 || o_id !== 2'd0 || o_data !== 8'h10) begin
            failures++;
            $display("FAIL lk_after got rdy=%b id=%0d d=%h exp rdy=0010 id=0 d=10", i_ready, o_id, o_data);
        end
        tick();
        i_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (i_ready !== 4'b0000 || o_valid !== 1'b1 || o_id !== 2'd1 || o_data !== 8'h31) begin
            failures++;
            $display("FAIL lk_hold got rdy=%b v=%b id=%0d d=%h exp rdy=0000 v=1 id=1 d=31",
                     i_ready, o_valid, o_id, o_data);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (i_ready !== 4'b0000 || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL lk_stall c=%0d got rdy=%b v=%b exp rdy=0000 v=0", c, i_ready, o_valid);
            end
            tick();
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        i_valid = '0;
        i_data  = '0;
        o_ready = 1'b0;
`ifdef PIPE_ARB_LOCK_EN
        i_last  = '0;
`endif
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
`ifdef PIPE_ARB_LOCK_EN
        test_lock();
`endif
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- N-requester round-robin arbiter sharing one ready/valid pipe stage.
- Selects one valid requester per cycle and registers its beat into a single output data/valid register.
- Also registers the source index, so downstream can route responses.
- Sits in front of shared pipe resources, for example a single skid-buffered channel fed by several producers.

Parameters:
- DWIDTH, 8: data width per requester and on the output.
- NREQ, 4: number of requesters; legal range 2..16.
- IDW, $clog2(NREQ): width of the o_id field. Derived; never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_data  in  NREQ*DWIDTH  packed request data; requester k occupies bits [k*DWIDTH +: DWIDTH]
- i_valid  in  NREQ  per-requester valid
- i_ready  out  NREQ  per-requester ready; one-hot or zero
- o_data  out  DWIDTH  registered output data
- o_valid  out  1  registered output valid
- o_id  out  IDW  index of the requester that supplied o_data
- o_ready  in  1  downstream ready
- i_last  in  NREQ  end-of-packet marker per requester; present only with PIPE_ARB_LOCK_EN

Behaviour:
- Reset values: o_valid=0, o_data=0, o_id=0, i_ready=0, priority pointer ptr=0, lock state=UNLOCKED.
- Stage-free condition: adv = o_ready | ~o_valid.
- Grant selection (combinational): the first k with i_valid[k]=1, scanning ptr, ptr+1, … NREQ-1, 0, … ptr-1 (modulo NREQ).
- i_ready[g] = adv & i_valid[g] for the granted g only. All other bits are 0. Never assert i_ready to a non-valid requester. i_ready is combinational from o_ready; this is a deliberate choice.
- Transfer occurs when i_valid[g] & i_ready[g].
  - On transfer: o_data<=i_data[g], o_id<=g, o_valid<=1, ptr<=(g+1) mod NREQ.
- If adv=1 and no requester is valid: o_valid<=0; o_data, o_id and ptr hold.
- If adv=0: all output registers and ptr hold; no i_ready asserted.
- Latency: 1 cycle from accepted input to o_valid.
- Throughput: 1 beat/cycle when o_ready is held high.
- Fairness: each continuously valid requester is served at least once every NREQ transfers.
- Simultaneous o_ready and new grant in one cycle: the output beat is consumed and the new beat is loaded in the same edge. No bubble.
- ptr wrap: g=NREQ-1 sets ptr to 0.
- Reset asserted mid-transfer wins: all state returns to reset values next edge. An in-flight o_valid beat is dropped.
- Requester protocol assumption, checked by assertion in the bench: once i_valid[k] is asserted, it holds with stable data until accepted.

Optional Feature:
- Macro: PIPE_ARB_LOCK_EN.
- Defined:
  - i_last port exists; two-state FSM UNLOCKED/LOCKED plus a lock_id register.
  - UNLOCKED -> LOCKED on a transfer from g with i_last[g]=0; lock_id<=g.
  - While LOCKED, the grant is forced to lock_id. Other requesters are never granted, even if lock_id is not valid; the pipe stalls.
  - LOCKED -> UNLOCKED on a transfer from lock_id with i_last=1.
  - ptr updates only on transfers with i_last=1, so fairness is counted per packet.
- Undefined: no i_last port, no FSM; per-beat arbitration as above.

Decomposition:
- Package pipe_arb_pkg holds:
  - lock-state localparams (UNLOCKED=1'b0, LOCKED=1'b1);
  - a function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module: pipe_rr_pick, the combinational rotate/priority-encode/unrotate. Inputs req[NREQ], ptr[IDW]; outputs gnt_oh[NREQ], gnt_id[IDW], any. Instantiated once.

Test Plan:
- Reset then idle, NREQ=4: rst=1 for 2 cycles, then i_valid=0 -> o_valid=0, i_ready=0000, o_id=0 throughout.
- All four valid, o_ready=1, data k=8'hA0+k: o_id sequence 0,1,2,3,0,… every cycle, o_data matching; i_ready one-hot rotating.
- Backpressure: requester 2 valid with 8'h55, o_ready=0 while o_valid=1 -> i_ready=0000, o_data holds 8'h55. Release o_ready -> next beat loads on the same edge the 8'h55 beat is consumed.
- Wrap and skip: ptr=3, only requesters 1 and 3 valid -> grants 3, then 1, then 3.
- Reset mid-stream: assert rst while o_valid=1 -> next edge o_valid=0, ptr=0. First post-reset grant goes to the lowest valid index.
- PIPE_ARB_LOCK_EN: requester 1 sends 3 beats with i_last=0,0,1 while requester 0 is valid -> o_id=1,1,1 then 0. If requester 1 drops i_valid mid-packet, o_valid goes to 0 and requester 0 is not granted.
